mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. Sits between the EX/ME pipeline register and the ME/WB pipeline register. Performs loads and stores (byte, half, word) against a data memory with a req/ready handshake and formats load data with sign or zero extension. Stalls the front of the pipeline while an access is outstanding and inserts a bubble into ME/WB until the access completes.

## Interface
- TIMEOUT, 16: max REQ cycles waiting for dmem_ready before abort (≥1, counter width $clog2(TIMEOUT+1))
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- me_memRead  in  1  load in ME
- me_memWrite  in  1  store in ME
- me_funct3  in  3  access width/sign (RV32I encoding)
- me_outAlu  in  32  effective address / ALU result
- me_storeData  in  32  rs2 value for stores
- me_writeReg, me_aluOut_WB_memOut  in  1 each  WB controls from EX/ME
- me_rd  in  5  destination register
- out_writeReg  out  1  to ME/WB; masked while stalling or on error
- out_aluOut_WB_memOut  out  1  passthrough
- out_outMem  out  32  formatted load data
- out_outAlu  out  32  passthrough of me_outAlu
- out_rd  out  5  passthrough of me_rd
- me_stall  out  1  freeze PC, IF/ID, ID/EX, EX/ME
- me_misalign  out  1  one-cycle pulse, misaligned/illegal access
- me_buserr  out  1  one-cycle pulse, handshake timeout
- dmem_req, dmem_we  out  1 each  registered bus request / write enable
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data, replicated per lane
- dmem_wstrb  out  4  byte-lane enables
- dmem_ready  in  1  access accepted/complete this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready

## Operation
- Access = me_memRead | me_memWrite; memWrite wins if both set (no read performed).
- Legal: load funct3 000/001/010/100/101, store 000/001/010; half needs addr[0]=0, word needs addr[1:0]=0. Anything else → error.
- States IDLE, REQ, DONE.
- IDLE, no access: me_stall=0, out_writeReg=me_writeReg, out_outMem=0.
- IDLE, illegal access: no request, me_misalign=1, me_stall=0, out_writeReg=0, stay IDLE.
- IDLE, legal access: me_stall=1, out_writeReg=0; register dmem_req=1, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata; counter=0; → REQ.
- REQ: bus outputs held stable; me_stall=1, out_writeReg=0. dmem_ready=1: capture dmem_rdata (reads), drop dmem_req/dmem_we, → DONE. Else counter+1; counter reaching TIMEOUT-1 without ready: drop req, captured data=0, error flag set, → DONE.
- DONE: me_stall=0; out_outMem = formatted captured word; out_writeReg = me_writeReg & ~error; me_buserr = error; clear error; → IDLE. Upstream advances this cycle so IDLE never re-issues the same instruction.
- Store lanes by addr[1:0]: SB wstrb=0001<<a, wdata={4{rs2[7:0]}}; SH wstrb=0011<<a, wdata={2{rs2[15:0]}}; SW 1111, rs2.
- Load: select byte/half at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- out_outAlu, out_rd, out_aluOut_WB_memOut are combinational passthroughs.

## Timing
- Reset (async, any state): state=IDLE, dmem_req/dmem_we=0, dmem_addr/dmem_wdata/dmem_wstrb=0, captured data=0, counter=0, error=0. While rst=1: me_stall, me_misalign, me_buserr, out_writeReg, out_outMem = 0. Reset during REQ aborts the transaction immediately; no completion is reported.
- Min access: 2 stall cycles (IDLE-decide, REQ with ready) + DONE, so an instruction spends 3 cycles in ME; each extra non-ready REQ cycle adds one.
- dmem_req rises the cycle after IDLE decides; falls the cycle after ready sampled.
- Timeout: REQ lasts exactly TIMEOUT cycles; me_buserr high in the following DONE cycle only.
- me_misalign is combinational, high for exactly the one IDLE cycle (no stall).
- Stores write nothing back: me_writeReg=0 from decode, passed as-is in DONE.

## Test plan
- LW addr 0x100, ready first REQ cycle, rdata 0xDEADBEEF → stall 2 cycles, DONE out_outMem=0xDEADBEEF, out_writeReg=1.
- LB addr 0x103, rdata 0x80123456; LBU same → 0xFFFFFF80 / 0x00000080.
- SH addr 0x102, rs2 0x0000ABCD → dmem_we=1, wstrb=1100, wdata=0xABCDABCD, held until ready after 3 wait cycles.
- LW addr 0x101 → no dmem_req, me_misalign one cycle, out_writeReg=0, me_stall=0.
- TIMEOUT=4, ready never → req high 4 cycles, DONE: me_buserr=1, out_outMem=0, out_writeReg=0.
- Assert rst mid-REQ → dmem_req=0, me_stall=0 immediately; after release, next LW completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues byte/half/word loads and stores over a req/ready data bus,
// stalls the front of the pipeline while an access is outstanding and formats load data.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        me_memRead,
    input  logic        me_memWrite,
    input  logic [2:0]  me_funct3,
    input  logic [31:0] me_outAlu,
    input  logic [31:0] me_storeData,
    input  logic        me_writeReg,
    input  logic        me_aluOut_WB_memOut,
    input  logic [4:0]  me_rd,
    output logic        out_writeReg,
    output logic        out_aluOut_WB_memOut,
    output logic [31:0] out_outMem,
    output logic [31:0] out_outAlu,
    output logic [4:0]  out_rd,
    output logic        me_stall,
    output logic        me_misalign,
    output logic        me_buserr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;

    state_t          state;
    logic [CntW-1:0] waitCnt;
    logic [31:0]     capData;
    logic            busErr;

    logic        access;
    logic        isStore;
    logic        legal;
    logic [1:0]  byteOff;
    logic [3:0]  storeStrb;
    logic [31:0] storeData;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;
    logic [31:0] loadFmt;

    assign out_outAlu           = me_outAlu;
    assign out_rd               = me_rd;
    assign out_aluOut_WB_memOut = me_aluOut_WB_memOut;

    assign access  = me_memRead | me_memWrite;
    assign isStore = me_memWrite;
    assign byteOff = me_outAlu[1:0];

    // Legality: width from funct3[1:0], unsigned variants only exist for loads.
    always_comb begin
        legal = 1'b0;
        case (me_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~byteOff[0];
            3'b010:  legal = (byteOff == 2'b00);
            3'b100:  legal = ~isStore;
            3'b101:  legal = ~isStore & ~byteOff[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        storeStrb = 4'b1111;
        storeData = me_storeData;
        case (me_funct3[1:0])
            2'b00: begin
                storeStrb = 4'b0001 << byteOff;
                storeData = {4{me_storeData[7:0]}};
            end
            2'b01: begin
                storeStrb = 4'b0011 << byteOff;
                storeData = {2{me_storeData[15:0]}};
            end
            default: begin
                storeStrb = 4'b1111;
                storeData = me_storeData;
            end
        endcase
    end

    // Upstream is frozen until DONE, so funct3/address still describe the captured word.
    always_comb begin
        case (byteOff)
            2'b00:   ldByte = capData[7:0];
            2'b01:   ldByte = capData[15:8];
            2'b10:   ldByte = capData[23:16];
            default: ldByte = capData[31:24];
        endcase
        ldHalf = byteOff[1] ? capData[31:16] : capData[15:0];
        case (me_funct3)
            3'b000:  loadFmt = {{24{ldByte[7]}}, ldByte};
            3'b001:  loadFmt = {{16{ldHalf[15]}}, ldHalf};
            3'b100:  loadFmt = {24'h0, ldByte};
            3'b101:  loadFmt = {16'h0, ldHalf};
            default: loadFmt = capData;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_wstrb <= 4'h0;
            capData    <= 32'h0;
            waitCnt    <= '0;
            busErr     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (access && legal) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= isStore;
                        dmem_addr  <= {me_outAlu[31:2], 2'b00};
                        dmem_wstrb <= isStore ? storeStrb : 4'h0;
                        dmem_wdata <= isStore ? storeData : 32'h0;
                        waitCnt    <= '0;
                        state      <= StReq;
                    end
                end
                StReq: begin
                    if (dmem_ready) begin
                        capData  <= dmem_we ? 32'h0 : dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= StDone;
                    end else if (waitCnt == CntW'(TIMEOUT - 1)) begin
                        capData  <= 32'h0;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        busErr   <= 1'b1;
                        state    <= StDone;
                    end else begin
                        waitCnt <= waitCnt + CntW'(1);
                    end
                end
                StDone: begin
                    busErr <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Status outputs are forced low while reset is held, whatever the inputs say.
    always_comb begin
        me_stall     = 1'b0;
        me_misalign  = 1'b0;
        me_buserr    = 1'b0;
        out_writeReg = 1'b0;
        out_outMem   = 32'h0;
        if (!rst) begin
            case (state)
                StIdle: begin
                    if (!access) begin
                        out_writeReg = me_writeReg;
                    end else if (!legal) begin
                        me_misalign = 1'b1;
                    end else begin
                        me_stall = 1'b1;
                    end
                end
                StReq: me_stall = 1'b1;
                StDone: begin
                    out_outMem   = loadFmt;
                    out_writeReg = me_writeReg & ~busErr;
                    me_buserr    = busErr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected bus and ME/WB responses,
// monitors compare them as the DUT presents bus handshakes and instruction completions.
module tb_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        me_memRead, me_memWrite;
    logic [2:0]  me_funct3;
    logic [31:0] me_outAlu, me_storeData;
    logic        me_writeReg, me_aluOut_WB_memOut;
    logic [4:0]  me_rd;
    logic        out_writeReg, out_aluOut_WB_memOut;
    logic [31:0] out_outMem, out_outAlu;
    logic [4:0]  out_rd;
    logic        me_stall, me_misalign, me_buserr;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .me_memRead(me_memRead), .me_memWrite(me_memWrite), .me_funct3(me_funct3),
        .me_outAlu(me_outAlu), .me_storeData(me_storeData), .me_writeReg(me_writeReg),
        .me_aluOut_WB_memOut(me_aluOut_WB_memOut), .me_rd(me_rd),
        .out_writeReg(out_writeReg), .out_aluOut_WB_memOut(out_aluOut_WB_memOut),
        .out_outMem(out_outMem), .out_outAlu(out_outAlu), .out_rd(out_rd),
        .me_stall(me_stall), .me_misalign(me_misalign), .me_buserr(me_buserr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic [31:0] mem;
        logic        chkMem;
        logic        mis;
        logic        berr;
        int          stalls;
        int          reqs;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    resp_t respQ[$];
    bus_t  busQ[$];
    int    checks = 0;
    int    errors = 0;
    int    curWait = 0;
    logic [31:0] curRdata = 32'h0;
    int    age = 0;
    int    stallCnt = 0;
    int    reqCnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pushResp(input logic wreg, input logic [31:0] mem, input logic chkMem,
                            input logic mis, input logic berr, input int stalls,
                            input int reqs);
        resp_t r;
        r.wreg = wreg; r.mem = mem; r.chkMem = chkMem; r.mis = mis; r.berr = berr;
        r.stalls = stalls; r.reqs = reqs;
        respQ.push_back(r);
    endtask

    task automatic pushBus(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata);
        bus_t b;
        b.we = we; b.addr = addr; b.strb = strb; b.wdata = wdata;
        busQ.push_back(b);
    endtask

    // Memory model: ready after curWait non-ready REQ cycles; wrong data whenever not ready.
    always @(posedge clk) begin
        #1;
        if (dmem_req) begin
            dmem_ready = (age == curWait);
            dmem_rdata = (age == curWait) ? curRdata : ~curRdata;
            age++;
        end else begin
            dmem_ready = 1'b0;
            dmem_rdata = 32'h0;
            age = 0;
        end
    end

    always @(negedge clk) begin : monitor
        bus_t  b;
        resp_t r;
        if (rst) begin
            stallCnt = 0;
            reqCnt   = 0;
        end else begin
            if (dmem_req) reqCnt++;
            if (dmem_req && dmem_ready) begin
                if (busQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got req addr 0x%08h expected none", dmem_addr);
                end else begin
                    b = busQ.pop_front();
                    chk("bus_we", {31'h0, dmem_we}, {31'h0, b.we});
                    chk("bus_addr", dmem_addr, b.addr);
                    if (b.we) begin
                        chk("bus_wstrb", {28'h0, dmem_wstrb}, {28'h0, b.strb});
                        chk("bus_wdata", dmem_wdata, b.wdata);
                    end
                end
            end
            if (me_stall) begin
                stallCnt++;
            end else if (me_memRead || me_memWrite) begin
                if (respQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected: got completion expected none");
                end else begin
                    r = respQ.pop_front();
                    chk("resp_writeReg", {31'h0, out_writeReg}, {31'h0, r.wreg});
                    chk("resp_misalign", {31'h0, me_misalign}, {31'h0, r.mis});
                    chk("resp_buserr", {31'h0, me_buserr}, {31'h0, r.berr});
                    chk("resp_stalls", stallCnt, r.stalls);
                    chk("resp_reqCycles", reqCnt, r.reqs);
                    if (r.chkMem) chk("resp_outMem", out_outMem, r.mem);
                end
                stallCnt = 0;
                reqCnt   = 0;
            end
        end
    end

    task automatic idle();
        me_memRead = 1'b0; me_memWrite = 1'b0; me_funct3 = 3'b000;
        me_outAlu = 32'h0; me_storeData = 32'h0; me_writeReg = 1'b0;
        me_aluOut_WB_memOut = 1'b0; me_rd = 5'd0;
    endtask

    // Present one instruction and hold it until the stage stops stalling.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic wreg,
                       input int waitN, input logic [31:0] rdata);
        bit done = 1'b0;
        me_memRead = rd; me_memWrite = wr; me_funct3 = f3; me_outAlu = addr;
        me_storeData = sdata; me_writeReg = wreg; me_rd = 5'd9;
        curWait = waitN; curRdata = rdata;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!me_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL run_timeout: got stall held 40 cycles expected completion");
        end
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        // Legal load present during reset must not stall or request.
        me_memRead = 1'b1; me_funct3 = 3'b010; me_outAlu = 32'h100; me_writeReg = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, me_stall}, 32'h0);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_writeReg", {31'h0, out_writeReg}, 32'h0);
        chk("rst_outMem", out_outMem, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        idle();
        @(posedge clk); #1;
        rst = 1'b0;

        // No access: writeReg and passthroughs flow straight through.
        me_writeReg = 1'b1; me_outAlu = 32'h1234_5678; me_rd = 5'd17; me_aluOut_WB_memOut = 1'b1;
        #2;
        chk("idle_writeReg", {31'h0, out_writeReg}, 32'h1);
        chk("idle_outMem", out_outMem, 32'h0);
        chk("idle_stall", {31'h0, me_stall}, 32'h0);
        chk("idle_outAlu", out_outAlu, 32'h1234_5678);
        chk("idle_rd", {27'h0, out_rd}, 32'd17);
        chk("idle_wbSel", {31'h0, out_aluOut_WB_memOut}, 32'h1);
        @(posedge clk); #1;
        idle();

        // Loads
        pushBus(1'b0, 32'h100, 4'h0, 32'h0);
        pushResp(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 2, 1);
        run(1, 0, 3'b010, 32'h100, 32'h0, 1, 0, 32'hDEAD_BEEF);
        pushBus(1'b0, 32'h100, 4'h0, 32'h0);
        pushResp(1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 2, 1);
        run(1, 0, 3'b000, 32'h103, 32'h0, 1, 0, 32'h8012_3456);
        pushBus(1'b0, 32'h100, 4'h0, 32'h0);
        pushResp(1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 2, 1);
        run(1, 0, 3'b100, 32'h103, 32'h0, 1, 0, 32'h8012_3456);
        pushBus(1'b0, 32'h100, 4'h0, 32'h0);
        pushResp(1'b1, 32'hFFFF_8012, 1'b1, 1'b0, 1'b0, 4, 3);
        run(1, 0, 3'b001, 32'h102, 32'h0, 1, 2, 32'h8012_3456);
        pushBus(1'b0, 32'h100, 4'h0, 32'h0);
        pushResp(1'b1, 32'h0000_F456, 1'b1, 1'b0, 1'b0, 2, 1);
        run(1, 0, 3'b101, 32'h100, 32'h0, 1, 0, 32'h8012_F456);
        pushBus(1'b0, 32'h100, 4'h0, 32'h0);
        pushResp(1'b1, 32'h0000_0034, 1'b1, 1'b0, 1'b0, 2, 1);
        run(1, 0, 3'b000, 32'h101, 32'h0, 1, 0, 32'h8012_3456);

        // Stores
        pushBus(1'b1, 32'h100, 4'b1100, 32'hABCD_ABCD);
        pushResp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5, 4);
        run(0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 0, 3, 32'h0);
        pushBus(1'b1, 32'h100, 4'b0010, 32'h7878_7878);
        pushResp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3, 2);
        run(0, 1, 3'b000, 32'h101, 32'h1234_5678, 0, 1, 32'h0);
        pushBus(1'b1, 32'h200, 4'b1111, 32'hCAFE_F00D);
        pushResp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1);
        run(0, 1, 3'b010, 32'h200, 32'hCAFE_F00D, 0, 0, 32'h0);
        // Read and write both set: behaves as a store
        pushBus(1'b1, 32'h208, 4'b1111, 32'h0102_0304);
        pushResp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1);
        run(1, 1, 3'b010, 32'h208, 32'h0102_0304, 0, 0, 32'h5555_5555);

        // Illegal accesses: single-cycle misalign, no request, writeReg masked
        pushResp(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0);
        run(1, 0, 3'b010, 32'h101, 32'h0, 1, 0, 32'h0);
        pushResp(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0);
        run(1, 0, 3'b001, 32'h103, 32'h0, 1, 0, 32'h0);
        pushResp(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0);
        run(0, 1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0);
        pushResp(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0);
        run(1, 0, 3'b011, 32'h100, 32'h0, 1, 0, 32'h0);

        // Timeout: REQ lasts TO cycles, buserr in DONE, data zeroed, writeReg masked
        pushResp(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1 + TO, TO);
        run(1, 0, 3'b010, 32'h300, 32'h0, 1, 1000, 32'h1111_1111);

        // Reset in the middle of REQ aborts with nothing reported
        me_memRead = 1'b1; me_funct3 = 3'b010; me_outAlu = 32'h400; me_writeReg = 1'b1;
        curWait = 1000; curRdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_req", {31'h0, dmem_req}, 32'h0);
        chk("abort_stall", {31'h0, me_stall}, 32'h0);
        chk("abort_writeReg", {31'h0, out_writeReg}, 32'h0);
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        pushBus(1'b0, 32'h104, 4'h0, 32'h0);
        pushResp(1'b1, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 2, 1);
        run(1, 0, 3'b010, 32'h104, 32'h0, 1, 0, 32'h1122_3344);

        repeat (3) @(posedge clk);
        chk("respQ_empty", respQ.size(), 32'h0);
        chk("busQ_empty", busQ.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
